seq_monitor: RTL and testbench
==============================

SEQ_MONITOR -- requirements
Module: seq_monitor

Interface
REQ-001 Parameter NUM_EVT, default 4, number of ordered event inputs; legal range 2..16.
REQ-002 Parameter TIMEOUT_W, default 8, width of the inter-event timeout counter and of timeout_val.
REQ-003 Derived IDX_W = clog2(NUM_EVT), minimum 1; width of step_out.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst_n  input  1  reset; asynchronous, active-low.
REQ-006 clr  input  1  synchronous clear back to IDLE.
REQ-007 evt  input  NUM_EVT  event strobes; evt[k] is the k-th expected event.
REQ-008 timeout_val  input  TIMEOUT_W  maximum WAIT cycles between events; 0 disables the timeout.
REQ-009 done  output  1  sequence completed (Moore output).
REQ-010 err  output  1  sequence violated (Moore output).
REQ-011 err_code  output  2  error cause: 0 none, 1 order, 2 timeout.
REQ-012 state_out  output  2  current state encoding: IDLE=0, WAIT=1, DONE=2, ERROR=3.
REQ-013 step_out  output  IDX_W  index of the next expected event.

Function
REQ-014 States: IDLE, WAIT, DONE, ERROR; the state, the step index, the timeout counter and err_code shall be registered; all outputs shall be decoded from registers only.
REQ-015 clr=1 shall force IDLE, step=0, count=0, err_code=0 on the next edge, with priority over every other transition.
REQ-016 IDLE: if any evt[j] with j>0 is set, go to ERROR with err_code=1; otherwise, if evt[0] is set, go to WAIT with step=1 and count=0; otherwise stay.
REQ-017 WAIT, step=k: if any evt[j] with j>k is set, go to ERROR with err_code=1, taking priority over evt[k] in the same cycle.
REQ-018 WAIT, step=k: evt[j] with j<k shall be ignored (repeats are legal).
REQ-019 WAIT, step=k, evt[k] set, no order error: if k=NUM_EVT-1, go to DONE; otherwise step=k+1 and count=0.
REQ-020 WAIT, no advance: count shall increment by 1 and saturate at all-ones.
REQ-021 WAIT, timeout_val!=0, count==timeout_val-1, no advance: go to ERROR with err_code=2, so ERROR is entered after exactly timeout_val idle WAIT cycles.
REQ-022 Order error and timeout in the same cycle: err_code=1.
REQ-023 An advance in the same cycle as timeout expiry shall win; no error is raised.
REQ-024 done=1 exactly when state=DONE; err=1 exactly when state=ERROR.
REQ-025 Latency: done/err shall assert the cycle after the deciding event is sampled.
REQ-026 DONE and ERROR shall ignore evt; ERROR shall be left only by clr or reset.
REQ-027 step_out shall show 0 in IDLE and hold its last value in DONE and ERROR.
REQ-028 timeout_val shall be sampled every cycle; a change takes effect immediately against the current count.

Reset
REQ-029 rst_n=0 shall immediately set state=IDLE, step=0, count=0, err_code=0, giving done=0, err=0, state_out=0, step_out=0.
REQ-030 Reset asserted mid-sequence shall discard all progress; no done or err pulse shall result.
REQ-031 Reset deassertion shall be synchronised externally; the block samples evt from the first edge after release.

Configuration
REQ-032 Macro SEQ_MONITOR_AUTO_REARM_EN defined: DONE shall last exactly one cycle and then return to IDLE with step=0, so done is a 1-cycle pulse and evt[0] is accepted in the cycle after DONE.
REQ-033 Macro undefined: DONE is sticky until clr or reset; ERROR is sticky in both builds.

Verification
REQ-034 NUM_EVT=4, timeout_val=0, pulse evt[0..3] on cycles 1,3,5,7 -> done=1 from cycle 8, err=0, step_out sequence 1,2,3.
REQ-035 IDLE, evt=4'b0010 -> err=1 next cycle, err_code=1; clr -> IDLE, err=0.
REQ-036 timeout_val=5, evt[0] then silence -> err=1 with err_code=2 exactly 5 cycles after WAIT entry; a repeat of evt[0] during WAIT does not reset count.
REQ-037 step=2, evt=4'b1100 in the same cycle -> ERROR with err_code=1; separate run with evt[2] on the expiry cycle -> advance, no error.
REQ-038 rst_n pulsed low mid-WAIT between clock edges -> outputs zero without a clock edge; the sequence restarts cleanly.
REQ-039 Both macro builds: after completion, done is a 1-cycle pulse (macro) or holds until clr (no macro).

Source files
------------

// File: rtl/seq_monitor.sv
// seq_monitor: checks that NUM_EVT event strobes arrive in order, with an
// optional per-step inter-event timeout.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   clr          synchronous clear back to IDLE; beats every other transition
//   evt          event strobes; evt[k] is the k-th expected event
//   timeout_val  maximum idle WAIT cycles between events; 0 disables the timeout
//   done         high while in DONE
//   err          high while in ERROR
//   err_code     0 none, 1 order, 2 timeout
//   state_out    IDLE=0, WAIT=1, DONE=2, ERROR=3
//   step_out     index of the next expected event
//
// Build option: define SEQ_MONITOR_AUTO_REARM_EN to make DONE a one-cycle
// pulse that returns to IDLE. Without it, DONE holds until clr or reset.
module seq_monitor #(
    parameter int NUM_EVT   = 4,
    parameter int TIMEOUT_W = 8,
    localparam int IDX_W    = ($clog2(NUM_EVT) < 1) ? 1 : $clog2(NUM_EVT)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr,
    input  logic [NUM_EVT-1:0]   evt,
    input  logic [TIMEOUT_W-1:0] timeout_val,
    output logic                 done,
    output logic                 err,
    output logic [1:0]           err_code,
    output logic [1:0]           state_out,
    output logic [IDX_W-1:0]     step_out
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_DONE  = 2'd2,
        S_ERROR = 2'd3
    } state_t;

    localparam logic [1:0] E_NONE  = 2'd0;
    localparam logic [1:0] E_ORDER = 2'd1;
    localparam logic [1:0] E_TMO   = 2'd2;

    localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_EVT - 1);

    state_t               state, state_n;
    logic [IDX_W-1:0]     step, step_n;
    logic [TIMEOUT_W-1:0] count, count_n;
    logic [1:0]           code, code_n;

    logic ord_err;
    logic adv;
    logic tmo;

    // In IDLE step is 0, so the same comparison covers both
    // "any evt[j>0]" in IDLE and "any evt[j>k]" in WAIT.
    always_comb begin
        ord_err = 1'b0;
        adv     = 1'b0;
        for (int j = 0; j < NUM_EVT; j++) begin
            if (evt[j] && (j > int'(step))) ord_err = 1'b1;
            if (evt[j] && (j == int'(step))) adv = 1'b1;
        end
    end

    // Expiry on the cycle whose count is one short of the limit, so the
    // error lands after exactly timeout_val idle WAIT cycles.
    assign tmo = (timeout_val != '0) &&
                 (count == timeout_val - TIMEOUT_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            step  <= '0;
            count <= '0;
            code  <= E_NONE;
        end else begin
            state <= state_n;
            step  <= step_n;
            count <= count_n;
            code  <= code_n;
        end
    end

    always_comb begin
        state_n = state;
        step_n  = step;
        count_n = count;
        code_n  = code;
        if (clr) begin
            state_n = S_IDLE;
            step_n  = '0;
            count_n = '0;
            code_n  = E_NONE;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (ord_err) begin
                        state_n = S_ERROR;
                        code_n  = E_ORDER;
                    end else if (adv) begin
                        state_n = S_WAIT;
                        step_n  = IDX_W'(1);
                        count_n = '0;
                    end
                end
                S_WAIT: begin
                    if (ord_err) begin
                        state_n = S_ERROR;
                        code_n  = E_ORDER;
                    end else if (adv) begin
                        if (step == LAST) begin
                            state_n = S_DONE;
                        end else begin
                            step_n  = step + IDX_W'(1);
                            count_n = '0;
                        end
                    end else if (tmo) begin
                        state_n = S_ERROR;
                        code_n  = E_TMO;
                    end else if (count != '1) begin
                        count_n = count + TIMEOUT_W'(1);
                    end
                end
                S_DONE: begin
`ifdef SEQ_MONITOR_AUTO_REARM_EN
                    state_n = S_IDLE;
                    step_n  = '0;
                    count_n = '0;
`else
                    state_n = S_DONE;
`endif
                end
                S_ERROR: begin
                    state_n = S_ERROR;
                end
                default: begin
                    state_n = S_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        done      = (state == S_DONE);
        err       = (state == S_ERROR);
        err_code  = code;
        state_out = state;
        step_out  = step;
    end

endmodule

// File: tb/tb_seq_monitor.sv
// tb_seq_monitor: vector table plus hand sequences for seq_monitor
// (NUM_EVT=4, TIMEOUT_W=8).
module tb_seq_monitor;

    logic       clk;
    logic       rst_n;
    logic       clr;
    logic [3:0] evt;
    logic [7:0] timeout_val;
    logic       done;
    logic       err;
    logic [1:0] err_code;
    logic [1:0] state_out;
    logic [1:0] step_out;

    int checks   = 0;
    int failures = 0;

    seq_monitor #(
        .NUM_EVT   (4),
        .TIMEOUT_W (8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .clr         (clr),
        .evt         (evt),
        .timeout_val (timeout_val),
        .done        (done),
        .err         (err),
        .err_code    (err_code),
        .state_out   (state_out),
        .step_out    (step_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] e;
        logic [7:0] tv;
        logic       c;
        logic [1:0] st;
        logic [1:0] stp;
        logic [1:0] code;
    } vec_t;

    typedef struct {
        logic [1:0] st;
        logic [1:0] stp;
        logic [1:0] code;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];

    task automatic check(input string nm, input exp_t x);
        logic xd;
        logic xe;
        xd = (x.st == 2'd2);
        xe = (x.st == 2'd3);
        checks++;
        if (state_out !== x.st || step_out !== x.stp ||
            err_code !== x.code || done !== xd || err !== xe) begin
            failures++;
            $display("FAIL %s: got st=%0d step=%0d code=%0d done=%0b err=%0b, want st=%0d step=%0d code=%0d done=%0b err=%0b",
                     nm, state_out, step_out, err_code, done, err,
                     x.st, x.stp, x.code, xd, xe);
        end
    endtask

    // Drive one cycle of stimulus at the falling edge, queue the expected
    // registered result, and compare it just after the next rising edge.
    task automatic apply(input logic [3:0] e, input logic [7:0] tv,
                         input logic c, input logic [1:0] st,
                         input logic [1:0] stp, input logic [1:0] code,
                         input string nm);
        exp_t x;
        @(negedge clk);
        evt         = e;
        timeout_val = tv;
        clr         = c;
        sb.push_back('{st, stp, code});
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL %s: scoreboard empty", nm);
        end else begin
            x = sb.pop_front();
            check(nm, x);
        end
    endtask

    initial begin
        exp_t z;
        z = '{2'd0, 2'd0, 2'd0};

        // order / step / code table; every scenario ends in a clr
        // A: in-order run, timeout disabled, lower repeat ignored
        tbl.push_back('{4'b0001, 8'd0, 1'b0, 2'd1, 2'd1, 2'd0});
        tbl.push_back('{4'b0000, 8'd0, 1'b0, 2'd1, 2'd1, 2'd0});
        tbl.push_back('{4'b0010, 8'd0, 1'b0, 2'd1, 2'd2, 2'd0});
        tbl.push_back('{4'b0001, 8'd0, 1'b0, 2'd1, 2'd2, 2'd0});
        tbl.push_back('{4'b0100, 8'd0, 1'b0, 2'd1, 2'd3, 2'd0});
        tbl.push_back('{4'b0000, 8'd0, 1'b0, 2'd1, 2'd3, 2'd0});
        tbl.push_back('{4'b1000, 8'd0, 1'b0, 2'd2, 2'd3, 2'd0});
        tbl.push_back('{4'b0001, 8'd0, 1'b1, 2'd0, 2'd0, 2'd0});
        // B: out-of-order from IDLE, ERROR ignores evt, clr recovers
        tbl.push_back('{4'b0010, 8'd0, 1'b0, 2'd3, 2'd0, 2'd1});
        tbl.push_back('{4'b0001, 8'd0, 1'b0, 2'd3, 2'd0, 2'd1});
        tbl.push_back('{4'b0000, 8'd0, 1'b1, 2'd0, 2'd0, 2'd0});
        // C: evt[0] together with evt[1] in IDLE is an order error
        tbl.push_back('{4'b0011, 8'd0, 1'b0, 2'd3, 2'd0, 2'd1});
        tbl.push_back('{4'b0000, 8'd0, 1'b1, 2'd0, 2'd0, 2'd0});
        // D: step=2 with evt[2] and evt[3] together
        tbl.push_back('{4'b0001, 8'd0, 1'b0, 2'd1, 2'd1, 2'd0});
        tbl.push_back('{4'b0010, 8'd0, 1'b0, 2'd1, 2'd2, 2'd0});
        tbl.push_back('{4'b1100, 8'd0, 1'b0, 2'd3, 2'd2, 2'd1});
        tbl.push_back('{4'b0000, 8'd0, 1'b1, 2'd0, 2'd0, 2'd0});
        // E: tv=3, advance on the expiry cycle wins, then a real timeout
        tbl.push_back('{4'b0001, 8'd3, 1'b0, 2'd1, 2'd1, 2'd0});
        tbl.push_back('{4'b0010, 8'd3, 1'b0, 2'd1, 2'd2, 2'd0});
        tbl.push_back('{4'b0000, 8'd3, 1'b0, 2'd1, 2'd2, 2'd0});
        tbl.push_back('{4'b0000, 8'd3, 1'b0, 2'd1, 2'd2, 2'd0});
        tbl.push_back('{4'b0100, 8'd3, 1'b0, 2'd1, 2'd3, 2'd0});
        tbl.push_back('{4'b0000, 8'd3, 1'b0, 2'd1, 2'd3, 2'd0});
        tbl.push_back('{4'b0000, 8'd3, 1'b0, 2'd1, 2'd3, 2'd0});
        tbl.push_back('{4'b0000, 8'd3, 1'b0, 2'd3, 2'd3, 2'd2});
        tbl.push_back('{4'b1000, 8'd3, 1'b0, 2'd3, 2'd3, 2'd2});
        tbl.push_back('{4'b0000, 8'd3, 1'b1, 2'd0, 2'd0, 2'd0});
        // F: order error and timeout expiry in the same cycle -> order
        tbl.push_back('{4'b0001, 8'd1, 1'b0, 2'd1, 2'd1, 2'd0});
        tbl.push_back('{4'b0100, 8'd1, 1'b0, 2'd3, 2'd1, 2'd1});
        tbl.push_back('{4'b0000, 8'd1, 1'b1, 2'd0, 2'd0, 2'd0});
        // G: timeout_val raised from 0 mid-WAIT acts on current count
        tbl.push_back('{4'b0001, 8'd0, 1'b0, 2'd1, 2'd1, 2'd0});
        tbl.push_back('{4'b0000, 8'd0, 1'b0, 2'd1, 2'd1, 2'd0});
        tbl.push_back('{4'b0000, 8'd0, 1'b0, 2'd1, 2'd1, 2'd0});
        tbl.push_back('{4'b0000, 8'd3, 1'b0, 2'd3, 2'd1, 2'd2});
        tbl.push_back('{4'b0000, 8'd0, 1'b1, 2'd0, 2'd0, 2'd0});

        rst_n       = 1'b0;
        clr         = 1'b0;
        evt         = '0;
        timeout_val = '0;
        #3;
        check("reset_state", z);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            apply(tbl[i].e, tbl[i].tv, tbl[i].c, tbl[i].st,
                  tbl[i].stp, tbl[i].code, $sformatf("tbl[%0d]", i));
        end

        // timeout of 5 with a repeated evt[0] inside the window
        apply(4'b0001, 8'd5, 1'b0, 2'd1, 2'd1, 2'd0, "tmo_enter");
        apply(4'b0000, 8'd5, 1'b0, 2'd1, 2'd1, 2'd0, "tmo_c1");
        apply(4'b0001, 8'd5, 1'b0, 2'd1, 2'd1, 2'd0, "tmo_rep");
        apply(4'b0000, 8'd5, 1'b0, 2'd1, 2'd1, 2'd0, "tmo_c3");
        apply(4'b0000, 8'd5, 1'b0, 2'd1, 2'd1, 2'd0, "tmo_c4");
        apply(4'b0000, 8'd5, 1'b0, 2'd3, 2'd1, 2'd2, "tmo_fire");
        apply(4'b0000, 8'd5, 1'b1, 2'd0, 2'd0, 2'd0, "tmo_clr");

        // completion behaviour in each build
        apply(4'b0001, 8'd0, 1'b0, 2'd1, 2'd1, 2'd0, "done_e0");
        apply(4'b0010, 8'd0, 1'b0, 2'd1, 2'd2, 2'd0, "done_e1");
        apply(4'b0100, 8'd0, 1'b0, 2'd1, 2'd3, 2'd0, "done_e2");
        apply(4'b1000, 8'd0, 1'b0, 2'd2, 2'd3, 2'd0, "done_e3");
`ifdef SEQ_MONITOR_AUTO_REARM_EN
        apply(4'b0001, 8'd0, 1'b0, 2'd0, 2'd0, 2'd0, "rearm_idle");
        apply(4'b0001, 8'd0, 1'b0, 2'd1, 2'd1, 2'd0, "rearm_e0");
`else
        apply(4'b0001, 8'd0, 1'b0, 2'd2, 2'd3, 2'd0, "done_hold1");
        apply(4'b0000, 8'd0, 1'b0, 2'd2, 2'd3, 2'd0, "done_hold2");
`endif
        apply(4'b0000, 8'd0, 1'b1, 2'd0, 2'd0, 2'd0, "done_clr");

        // asynchronous reset between edges mid-WAIT
        apply(4'b0001, 8'd0, 1'b0, 2'd1, 2'd1, 2'd0, "ar_e0");
        apply(4'b0010, 8'd0, 1'b0, 2'd1, 2'd2, 2'd0, "ar_e1");
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_async", z);
        evt = '0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("ar_release", z);
        apply(4'b0000, 8'd0, 1'b0, 2'd0, 2'd0, 2'd0, "ar_idle");
        apply(4'b0001, 8'd0, 1'b0, 2'd1, 2'd1, 2'd0, "ar_restart");
        apply(4'b0010, 8'd0, 1'b0, 2'd1, 2'd2, 2'd0, "ar_step2");

        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL sb_drain: got %0d left, want 0", sb.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
